fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one of two requesters a single FIFO write, with ack/err/timeout resolution.
// Latency: req sampled in IDLE -> wr_en next cycle -> done/err the cycle after WAIT resolves (3 cycles min).
// Backpressure: full holds arbitration in IDLE; once issued, only wr_ack/wr_err/timeout end a transaction.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] d_in0,
    input  logic [DATA_WIDTH-1:0] d_in1,
    input  logic                  full,
    input  logic                  wr_ack,
    input  logic                  wr_err,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        BAD   = 2'b11
    } state_t;

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    state_t                state;
    state_t                state_nxt;
    logic                  rr;
    logic                  win_id;
    logic                  pick_id;
    logic [DATA_WIDTH-1:0] lat_dat;
    logic [3:0]            cnt;
    logic [3:0]            cnt_inc;
    logic                  start;
    logic                  resolve_ok;
    logic                  resolve_err;

    assign cnt_inc = cnt + 4'd1;

    // With both requesting the pointer decides; a lone requester always wins.
    assign pick_id = (req0 && req1) ? rr : req1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        resolve_ok  = 1'b0;
        resolve_err = 1'b0;
        case (state)
            IDLE: begin
                if ((req0 || req1) && !full) begin
                    start     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // An error response dominates a simultaneous ack.
                if (wr_err) begin
                    resolve_err = 1'b1;
                    state_nxt   = IDLE;
                end else if (wr_ack) begin
                    resolve_ok = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    resolve_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_en = 1'b0;
        d_out = '0;
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        case (state)
            ISSUE: begin
                wr_en = 1'b1;
                d_out = lat_dat;
                gnt0  = ~win_id;
                gnt1  = win_id;
            end
            WAIT: begin
                gnt0 = ~win_id;
                gnt1 = win_id;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr      <= 1'b0;
            win_id  <= 1'b0;
            lat_dat <= '0;
            cnt     <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            done0 <= resolve_ok & ~win_id;
            done1 <= resolve_ok & win_id;
            err0  <= resolve_err & ~win_id;
            err1  <= resolve_err & win_id;
            if (start) begin
                win_id  <= pick_id;
                lat_dat <= pick_id ? d_in1 : d_in0;
            end
            // ISSUE always leads to WAIT, so clearing here starts every WAIT at zero.
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt_inc;
            end
            if (resolve_ok || resolve_err) begin
                rr <= ~win_id;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus hand-written timeout/full/alternation sequences.
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] d_in0 = '0;
    logic [7:0] d_in1 = '0;
    logic       full = 1'b0;
    logic       wr_ack = 1'b0;
    logic       wr_err = 1'b0;
    logic       wr_en;
    logic [7:0] d_out;
    logic       gnt0, gnt1, done0, done1, err0, err1;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .d_in0(d_in0), .d_in1(d_in1),
        .full(full), .wr_ack(wr_ack), .wr_err(wr_err),
        .wr_en(wr_en), .d_out(d_out), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, r0, r1;
        logic [7:0] d0, d1;
        logic       fl, ack, er;
        logic       e_wr;
        logic [7:0] e_dout;
        logic       e_g0, e_g1, e_dn0, e_dn1, e_er0, e_er1, e_rr;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rst_n, r0, r1, input logic [7:0] d0, d1,
                                input logic fl, ack, er, e_wr, input logic [7:0] e_dout,
                                input logic e_g0, e_g1, e_dn0, e_dn1, e_er0, e_er1, e_rr);
        vec_t v;
        v.rst_n = rst_n; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
        v.fl = fl; v.ack = ack; v.er = er; v.e_wr = e_wr; v.e_dout = e_dout;
        v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_dn0 = e_dn0; v.e_dn1 = e_dn1;
        v.e_er0 = e_er0; v.e_er1 = e_er1; v.e_rr = e_rr;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; full = 1'b0; wr_ack = 1'b0; wr_err = 1'b0;
        d_in0 = '0; d_in1 = '0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g0_cnt, wr_cnt, last_g, nxt_g, last_dn0, last_dn1, n_gr;
        //   rst r0 r1 d0     d1    fl ack er | wr dout  g0 g1 dn0 dn1 er0 er1 rr
        // single requester 0, acked in first WAIT cycle; data change after latch ignored
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 8'hA5, 8'h00, 0, 0, 0,   1, 8'hA5, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        // requester 1 gets ack+err together -> err only
        add(1, 0, 1, 8'h00, 8'h3C, 0, 0, 0,   1, 8'h3C, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'h3C, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'h3C, 0, 1, 1,   0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        // both requesting: 0,1,0 with re-arbitration in the done cycle
        add(1, 1, 1, 8'h11, 8'h22, 0, 0, 0,   1, 8'h11, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 8'h11, 8'h22, 0, 0, 0,   0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 8'h11, 8'h22, 0, 1, 0,   0, 8'h00, 0, 0, 1, 0, 0, 0, 1);
        add(1, 1, 1, 8'h11, 8'h22, 0, 0, 0,   1, 8'h22, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 8'h11, 8'h22, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0, 0, 1);
        add(1, 1, 1, 8'h11, 8'h22, 0, 1, 0,   0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
        add(1, 1, 1, 8'h11, 8'h22, 0, 0, 0,   1, 8'h11, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 8'h11, 8'h22, 0, 0, 0,   0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 8'h11, 8'h22, 0, 1, 0,   0, 8'h00, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        // full holds IDLE (ack there ignored); full during ISSUE/WAIT does not abort
        add(1, 0, 1, 8'h00, 8'h5A, 1, 1, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'h5A, 1, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'h5A, 0, 0, 0,   1, 8'h5A, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'h5A, 1, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'h5A, 1, 1, 0,   0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        // lone requester 1 wins with rr=0; wr_err alone
        add(1, 0, 1, 8'h00, 8'h77, 0, 0, 0,   1, 8'h77, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 8'h00, 8'h77, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 8'h00, 8'h77, 0, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        // serve 0 (rr->1), then reset in WAIT of requester 1: no done, rr back to 0
        add(1, 1, 0, 8'h99, 8'h00, 0, 0, 0,   1, 8'h99, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 8'h99, 8'h00, 0, 0, 0,   0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 8'h99, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'hEE, 0, 0, 0,   1, 8'hEE, 0, 1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 8'h00, 8'hEE, 0, 0, 0,   0, 8'h00, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            reset_n = vq[i].rst_n; req0 = vq[i].r0; req1 = vq[i].r1;
            d_in0 = vq[i].d0; d_in1 = vq[i].d1;
            full = vq[i].fl; wr_ack = vq[i].ack; wr_err = vq[i].er;
            tick();
            check($sformatf("vec%0d {wr,dout,g0,g1,dn0,dn1,er0,er1,rr}", i),
                  {16'h0, wr_en, d_out, gnt0, gnt1, done0, done1, err0, err1, dut.rr},
                  {16'h0, vq[i].e_wr, vq[i].e_dout, vq[i].e_g0, vq[i].e_g1,
                   vq[i].e_dn0, vq[i].e_dn1, vq[i].e_er0, vq[i].e_er1, vq[i].e_rr});
        end

        // Timeout: 15 WAIT cycles with grant held, err0 on the 16th edge after ISSUE.
        do_reset();
        req0 = 1'b1; d_in0 = 8'hC3;
        tick();
        check("timeout_issue {wr,dout}", {23'h0, wr_en, d_out}, {23'h0, 1'b1, 8'hC3});
        n = 0; g0_cnt = 0; wr_cnt = 0;
        while (n < 40) begin
            tick();
            n++;
            if (err0) break;
            if (gnt0) g0_cnt++;
            if (wr_en) wr_cnt++;
        end
        req0 = 1'b0;
        check("timeout_edges_to_err0", n, 16);
        check("timeout_wait_gnt0_cycles", g0_cnt, 15);
        check("timeout_extra_wr_en", wr_cnt, 0);
        check("timeout_err_cycle {gnt0,done0,err1}", {gnt0, done0, err1}, 3'b000);
        tick();
        check("timeout_idle {wr,g0,err0,rr}", {wr_en, gnt0, err0, dut.rr}, 4'b0001);

        // Full held for 10 cycles blocks requester 1; issue on the edge after it drops.
        do_reset();
        full = 1'b1; req1 = 1'b1; d_in1 = 8'h66;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("full_blocked%0d {wr,g1}", i), {wr_en, gnt1}, 2'b00);
        end
        full = 1'b0;
        tick();
        check("full_release {wr,g1,dout}", {wr_en, gnt1, d_out}, {2'b11, 8'h66});
        wr_ack = 1'b1;
        tick();
        tick();
        check("full_release_done1", {done1, err1}, 2'b10);
        req1 = 1'b0; wr_ack = 1'b0;

        // Continuous contention, always acked: grants alternate from 0, dones every 6 cycles.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; d_in0 = 8'h01; d_in1 = 8'h02; wr_ack = 1'b1;
        last_g = -1; last_dn0 = -1; last_dn1 = -1; n_gr = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (wr_en) begin
                nxt_g = (last_g < 0) ? 0 : 1 - last_g;
                check($sformatf("alt_grant_c%0d", cyc), {gnt1, gnt0, d_out},
                      {nxt_g[0], ~nxt_g[0], (nxt_g == 1) ? 8'h02 : 8'h01});
                last_g = gnt1 ? 1 : 0;
                n_gr++;
            end
            if (done0) begin
                if (last_dn0 >= 0) check($sformatf("alt_done0_gap_c%0d", cyc), cyc - last_dn0, 6);
                last_dn0 = cyc;
            end
            if (done1) begin
                if (last_dn1 >= 0) check($sformatf("alt_done1_gap_c%0d", cyc), cyc - last_dn1, 6);
                last_dn1 = cyc;
            end
        end
        check("alt_grant_count", n_gr, 10);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
